l1i_refill_unit: RTL
====================

// Module: l1i_refill_unit
// PURPOSE
// Miss-refill engine directly downstream of the L1 instruction cache's miss port and upstream of its update port.
// Captures cache misses (line address, Pid, Tid) and requests the 64-byte line from the L2/memory bus.
// Assembles the line from eight 64-bit beats, then returns it to the cache as a one-cycle update.
// Up to 2 misses pending; duplicate-line misses filtered.
// PARAMETERS
// fetchingAddressWidth     64   byte address width
// cacheLineWith            512  line width in bits (64 bytes)
// offsetWidth              6    line offset bits; zeroed in all outgoing addresses
// PidSize                  20   process id width
// TidSize                  16   thread id width
// busWidth                 64   memory data beat width; beats = cacheLineWith/busWidth = 8
// PORTS
// clock_i                  in   1    clock, rising edge
// reset_i                  in   1    asynchronous, active-low reset
// flush_i                  in   1    drop all pending/in-flight refills
// cacheMiss_i              in   1    miss strobe from L1I
// missedAddress_i          in   64   missed fetch address
// missedPid_i              in   20   Pid of missing fetch
// missedTid_i              in   16   Tid of missing fetch
// memReq_o                 out  1    line read request valid
// memReqAddress_o          out  64   line-aligned request address
// memReqPid_o              out  20   request Pid
// memReqTid_o              out  16   request Tid
// memReqReady_i            in   1    memory accepts request this cycle
// memDataValid_i           in   1    data beat valid
// memData_i                in   64   data beat, lowest address first
// memDataLast_i            in   1    final beat marker
// cacheUpdate_o            out  1    one-cycle line write strobe to L1I
// cacheUpdateAddress_o     out  64   line-aligned address
// cacheUpdateLine_o        out  512  assembled line
// cacheUpdatePid_o         out  20   Pid of line
// cacheUpdateTid_o         out  16   Tid of line
// refillBusy_o             out  1    FSM not IDLE or queue non-empty
// missQueueFull_o          out  1    2 entries held
// refillError_o            out  1    one-cycle pulse on beat-count protocol error
// BEHAVIOUR
// - Reset (reset_i=0, async): every output 0, queue empty, beat counter 0, FSM IDLE.
// - Enqueue: on a clock edge with cacheMiss_i=1, store {address with offset zeroed, Pid, Tid}.
//   The miss is dropped if:
//   - the queue is full, or
//   - the same line address and Pid is already queued or in flight.
// - FSM states:
//   - IDLE: if the queue is non-empty, pop the head and go to REQ. An enqueue at edge N gives memReq_o=1 after edge N+1.
//   - REQ: memReq_o=1 with address/Pid/Tid held stable. At the edge where memReqReady_i=1, go to FILL with beat counter=0.
//   - FILL: on each memDataValid_i, write beat k to line bits [64k:64k+63] and increment k.
//     - Beat 7 with memDataLast_i=1: go to WRITE.
//     - memDataLast_i=1 with k<7: pulse refillError_o, discard the line, go to IDLE.
//     - Beat 7 without last: pulse refillError_o, go to DRAIN.
//   - DRAIN: consume beats until memDataLast_i, then go to IDLE with no update.
//   - WRITE: cacheUpdate_o=1 for exactly one cycle with the line, address, Pid and Tid, then go to IDLE.
// - Back-to-back: the minimum gap between consecutive cacheUpdate_o pulses is REQ+8 beats+WRITE+IDLE.
// - Update-output hold: cacheUpdateLine_o, cacheUpdateAddress_o, cacheUpdatePid_o and cacheUpdateTid_o hold their last value; only cacheUpdate_o is a pulse.
// - Simultaneous events:
//   - An enqueue in the same cycle as an IDLE pop is legal: the FIFO writes and reads together.
//   - A full queue is checked before the pop.
// - flush_i (highest priority after reset):
//   - The queue empties.
//   - In REQ, memReq_o deasserts next cycle and the FSM goes to IDLE.
//   - In FILL, go to DRAIN.
//   - In WRITE, the pulse is suppressed.
//   - A miss arriving with flush_i is dropped.
// - Reset mid-refill: abandon immediately; memory-side cleanup is the bus owner's job.
// STRUCTURE
// - Shared package l1i_pkg:
//   - width parameters, beats-per-line constant;
//   - FSM state enum {IDLE,REQ,FILL,DRAIN,WRITE};
//   - miss-entry typedef {addr,Pid,Tid}.
// - Sub-module l1i_miss_fifo:
//   - 2-entry FIFO of miss entries;
//   - a match port for the duplicate filter;
//   - full/empty flags.
// - Top level: FSM, beat counter, line assembly register.
// TESTING
// - Single miss, addr 0x1234, Pid 5 -> memReq_o at 0x1200. Ready after 2 cycles, then 8 beats 0..7 -> cacheUpdate_o pulse, line words 0..7, Pid 5.
// - Same-line misses 0x1240 and 0x1278 on consecutive cycles -> one request only, queue depth 1.
// - Three distinct misses while busy -> third dropped, missQueueFull_o=1; two updates issue in order.
// - memDataLast_i on beat 3 -> refillError_o pulses once, no cacheUpdate_o, FSM returns to IDLE.
// - flush_i during FILL beat 4 -> remaining beats drained, no update, queue empty.
// - reset_i low mid-FILL (async, between edges) -> all outputs 0 immediately; a new miss after release refills correctly.

Source files
------------

// File: rtl/l1i_pkg.sv
// Shared widths, FSM states and miss-entry payload for the L1I refill path.
package l1i_pkg;

  localparam int unsigned fetchingAddressWidth = 64;
  localparam int unsigned cacheLineWith        = 512;
  localparam int unsigned offsetWidth          = 6;
  localparam int unsigned PidSize              = 20;
  localparam int unsigned TidSize              = 16;
  localparam int unsigned busWidth             = 64;
  localparam int unsigned beatsPerLine         = cacheLineWith / busWidth;
  localparam int unsigned beatCntWidth         = $clog2(beatsPerLine);

  typedef enum logic [2:0] {IDLE, REQ, FILL, DRAIN, WRITE} refillState_t;

  typedef struct packed {
    logic [fetchingAddressWidth-1:0] addr;
    logic [PidSize-1:0]              pid;
    logic [TidSize-1:0]              tid;
  } missEntry_t;

  // Clear the line-offset bits of a byte address.
  function automatic logic [fetchingAddressWidth-1:0] lineAlign(
    input logic [fetchingAddressWidth-1:0] a
  );
    return a & ~((fetchingAddressWidth'(1) << offsetWidth) - fetchingAddressWidth'(1));
  endfunction

endpackage

// File: rtl/l1i_miss_fifo.sv
// Two-entry miss queue with a line/Pid match port used to filter duplicate misses.
module l1i_miss_fifo
  import l1i_pkg::*;
(
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            flush,
  input  logic                            push,
  input  logic                            pop,
  input  missEntry_t                      pushEntry,
  output missEntry_t                      headEntry,
  input  logic [fetchingAddressWidth-1:0] matchAddr,
  input  logic [PidSize-1:0]              matchPid,
  output logic                            matchHit_c,
  output logic                            full,
  output logic                            empty,
  output logic                            nonEmptyNext_c
);

  localparam int unsigned depth = 2;

  missEntry_t entries [depth];
  logic       rdPtr;
  logic       wrPtr;
  logic [1:0] count;
  logic [1:0] countNext;
  logic       doPush;
  logic       doPop;

  always_comb begin
    doPush    = push && !full;
    doPop     = pop && !empty;
    countNext = count;
    if (flush) countNext = '0;
    else       countNext = count + 2'(doPush) - 2'(doPop);
  end

  assign nonEmptyNext_c = (countNext != 2'd0);
  assign headEntry      = entries[rdPtr];

  // Slot i is live when the queue is full, or it is the head of a non-empty queue.
  always_comb begin
    matchHit_c = 1'b0;
    for (int i = 0; i < depth; i++) begin
      if (((count == 2'd2) || ((count != 2'd0) && (rdPtr == 1'(i)))) &&
          (entries[i].addr == matchAddr) && (entries[i].pid == matchPid))
        matchHit_c = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdPtr <= 1'b0;
      wrPtr <= 1'b0;
      count <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
      for (int i = 0; i < depth; i++) entries[i] <= '0;
    end else begin
      count <= countNext;
      full  <= (countNext == 2'd2);
      empty <= (countNext == 2'd0);
      if (flush) begin
        rdPtr <= 1'b0;
        wrPtr <= 1'b0;
      end else begin
        if (doPush) begin
          entries[wrPtr] <= pushEntry;
          wrPtr          <= ~wrPtr;
        end
        if (doPop) rdPtr <= ~rdPtr;
      end
    end
  end

endmodule

// File: rtl/l1i_refill_unit.sv
// L1I miss-refill engine: queues misses, requests lines from memory,
// assembles eight beats and returns the line to the cache as a one-cycle update.
module l1i_refill_unit
  import l1i_pkg::*;
(
  input  logic                            clock_i,
  input  logic                            reset_i,
  input  logic                            flush_i,
  input  logic                            cacheMiss_i,
  input  logic [fetchingAddressWidth-1:0] missedAddress_i,
  input  logic [PidSize-1:0]              missedPid_i,
  input  logic [TidSize-1:0]              missedTid_i,
  output logic                            memReq_o,
  output logic [fetchingAddressWidth-1:0] memReqAddress_o,
  output logic [PidSize-1:0]              memReqPid_o,
  output logic [TidSize-1:0]              memReqTid_o,
  input  logic                            memReqReady_i,
  input  logic                            memDataValid_i,
  input  logic [busWidth-1:0]             memData_i,
  input  logic                            memDataLast_i,
  output logic                            cacheUpdate_o,
  output logic [fetchingAddressWidth-1:0] cacheUpdateAddress_o,
  output logic [cacheLineWith-1:0]        cacheUpdateLine_o,
  output logic [PidSize-1:0]              cacheUpdatePid_o,
  output logic [TidSize-1:0]              cacheUpdateTid_o,
  output logic                            refillBusy_o,
  output logic                            missQueueFull_o,
  output logic                            refillError_o
);

  localparam logic [beatCntWidth-1:0] lastBeat = beatCntWidth'(beatsPerLine - 1);

  refillState_t             state;
  refillState_t             stateNext;
  logic [beatCntWidth-1:0]  beatCnt;
  logic [beatCntWidth-1:0]  beatCntNext;
  logic [cacheLineWith-1:0] lineBuf;
  missEntry_t               missEntry;
  missEntry_t               fifoHead;
  logic                     fifoPush;
  logic                     fifoPop;
  logic                     fifoHit;
  logic                     fifoFull;
  logic                     fifoEmpty;
  logic                     fifoNonEmptyNext;
  logic                     inFlightHit;
  logic                     beatWrite;
  logic                     errorNext;
  logic                     updateNext;

  assign missEntry   = '{addr: lineAlign(missedAddress_i), pid: missedPid_i, tid: missedTid_i};
  // The memReq* registers double as the record of the refill currently in flight.
  assign inFlightHit = (state != IDLE) && (memReqAddress_o == missEntry.addr) &&
                       (memReqPid_o == missEntry.pid);
  assign fifoPush    = cacheMiss_i && !flush_i && !fifoFull && !fifoHit && !inFlightHit;
  assign missQueueFull_o = fifoFull;

  l1i_miss_fifo missFifo (
    .clk            (clock_i),
    .rst_n          (reset_i),
    .flush          (flush_i),
    .push           (fifoPush),
    .pop            (fifoPop),
    .pushEntry      (missEntry),
    .headEntry      (fifoHead),
    .matchAddr      (missEntry.addr),
    .matchPid       (missEntry.pid),
    .matchHit_c     (fifoHit),
    .full           (fifoFull),
    .empty          (fifoEmpty),
    .nonEmptyNext_c (fifoNonEmptyNext)
  );

  always_comb begin
    stateNext   = state;
    beatCntNext = beatCnt;
    fifoPop     = 1'b0;
    beatWrite   = 1'b0;
    errorNext   = 1'b0;
    updateNext  = 1'b0;
    case (state)
      IDLE: begin
        if (!flush_i && !fifoEmpty) begin
          fifoPop   = 1'b1;
          stateNext = REQ;
        end
      end
      REQ: begin
        // A request accepted in the flush cycle still returns beats, so drain them.
        if (flush_i) stateNext = memReqReady_i ? DRAIN : IDLE;
        else if (memReqReady_i) begin
          stateNext   = FILL;
          beatCntNext = '0;
        end
      end
      FILL: begin
        if (memDataValid_i) begin
          beatWrite   = !flush_i;
          beatCntNext = beatCnt + beatCntWidth'(1);
          if (memDataLast_i) begin
            if (flush_i) stateNext = IDLE;
            else if (beatCnt == lastBeat) stateNext = WRITE;
            else begin
              errorNext = 1'b1;
              stateNext = IDLE;
            end
          end else if (flush_i) stateNext = DRAIN;
          else if (beatCnt == lastBeat) begin
            errorNext = 1'b1;
            stateNext = DRAIN;
          end
        end else if (flush_i) stateNext = DRAIN;
      end
      DRAIN: begin
        if (memDataValid_i && memDataLast_i) stateNext = IDLE;
      end
      WRITE: begin
        updateNext = !flush_i;
        stateNext  = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state                <= IDLE;
      beatCnt              <= '0;
      lineBuf              <= '0;
      memReq_o             <= 1'b0;
      memReqAddress_o      <= '0;
      memReqPid_o          <= '0;
      memReqTid_o          <= '0;
      cacheUpdate_o        <= 1'b0;
      cacheUpdateAddress_o <= '0;
      cacheUpdateLine_o    <= '0;
      cacheUpdatePid_o     <= '0;
      cacheUpdateTid_o     <= '0;
      refillBusy_o         <= 1'b0;
      refillError_o        <= 1'b0;
    end else begin
      state         <= stateNext;
      beatCnt       <= beatCntNext;
      memReq_o      <= (stateNext == REQ);
      cacheUpdate_o <= updateNext;
      refillError_o <= errorNext;
      refillBusy_o  <= (stateNext != IDLE) || fifoNonEmptyNext;
      if (beatWrite) lineBuf[beatCnt * busWidth +: busWidth] <= memData_i;
      if (fifoPop) begin
        memReqAddress_o <= fifoHead.addr;
        memReqPid_o     <= fifoHead.pid;
        memReqTid_o     <= fifoHead.tid;
      end
      if (updateNext) begin
        cacheUpdateLine_o    <= lineBuf;
        cacheUpdateAddress_o <= memReqAddress_o;
        cacheUpdatePid_o     <= memReqPid_o;
        cacheUpdateTid_o     <= memReqTid_o;
      end
    end
  end

endmodule
